// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter
// N-master to 1-slave Wishbone classic arbiter with rotating priority.
// A grant covers a whole CYC, so multi-beat cycles are never split.
// One IDLE cycle always separates two consecutive grants.
// Optional feature: define WB_ARB_TIMEOUT_EN to force a bus error after
// TIMEOUT_CYCLES stalled beats. Without it the slave may stall forever.

module wb_rr_arbiter #(
  parameter int NMASTERS       = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             wb_clk_i,
  input  logic                             wb_rst_n_i,
  // master side, master i occupies slice i
  input  logic [NMASTERS*ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [NMASTERS*DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]            wbm_dat_o,
  input  logic [NMASTERS-1:0]              wbm_we_i,
  input  logic [NMASTERS*DATA_WIDTH/8-1:0] wbm_sel_i,
  input  logic [NMASTERS-1:0]              wbm_stb_i,
  input  logic [NMASTERS-1:0]              wbm_cyc_i,
  output logic [NMASTERS-1:0]              wbm_ack_o,
  output logic [NMASTERS-1:0]              wbm_err_o,
  // slave side
  output logic [ADDR_WIDTH-1:0]            wbs_adr_o,
  output logic [DATA_WIDTH-1:0]            wbs_dat_o,
  output logic                             wbs_we_o,
  output logic [DATA_WIDTH/8-1:0]          wbs_sel_o,
  output logic                             wbs_stb_o,
  output logic                             wbs_cyc_o,
  input  logic [DATA_WIDTH-1:0]            wbs_dat_i,
  input  logic                             wbs_ack_i,
  input  logic                             wbs_err_i,
  // debug / performance view of the current grant
  output logic [NMASTERS-1:0]              grant_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int PW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] ptr, ptr_next;
  logic [PW-1:0] gidx, gidx_next;
  logic [PW-1:0] pick;
  logic [PW-1:0] cand_idx;
  logic          found;
  int            cand;
  logic          busy;
  logic          cyc_g;
  logic          stb_g;
  logic          fire;

  assign busy  = (state == BUSY);
  assign cyc_g = wbm_cyc_i[gidx];
  assign stb_g = wbm_stb_i[gidx];

  // Round-robin search: first requester at or above ptr, wrapping past the top.
  always_comb begin
    pick     = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < NMASTERS; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NMASTERS) cand = cand - NMASTERS;
      cand_idx = PW'(cand);
      if (!found && wbm_cyc_i[cand_idx]) begin
        found = 1'b1;
        pick  = cand_idx;
      end
    end
  end

  // State, priority pointer and granted index registers.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= IDLE;
      ptr   <= '0;
      gidx  <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      gidx  <= gidx_next;
    end
  end

  // Next-state logic: grant in IDLE, release and rotate priority when CYC drops.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    gidx_next  = gidx;
    case (state)
      IDLE: begin
        if (|wbm_cyc_i) begin
          state_next = BUSY;
          gidx_next  = pick;
        end
      end
      BUSY: begin
        if (!cyc_g) begin
          state_next = IDLE;
          ptr_next   = (gidx == PW'(NMASTERS - 1)) ? '0 : gidx + 1'b1;
          gidx_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tcount;

  assign fire = busy && (tcount == CW'(TIMEOUT_CYCLES));

  // Stall counter: counts beats waiting on the slave, clears on any response or idle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      tcount <= '0;
    end else if (busy && wbs_stb_o && !wbs_ack_i && !wbs_err_i) begin
      tcount <= tcount + 1'b1;
    end else begin
      tcount <= '0;
    end
  end
`else
  // No forced error without the timeout; the length is never negative so this stays low.
  assign fire = (TIMEOUT_CYCLES < 0);
`endif

  // Output muxing: everything is zero unless a grant is active, so an async
  // reset drops CYC/STB and suppresses ack/err in the same cycle.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_we_o  = 1'b0;
    wbs_sel_o = '0;
    wbs_stb_o = 1'b0;
    wbs_cyc_o = 1'b0;
    wbm_dat_o = '0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    grant_o   = '0;
    if (busy) begin
      wbs_adr_o       = wbm_adr_i[gidx*ADDR_WIDTH +: ADDR_WIDTH];
      wbs_dat_o       = wbm_dat_i[gidx*DATA_WIDTH +: DATA_WIDTH];
      wbs_we_o        = wbm_we_i[gidx];
      wbs_sel_o       = wbm_sel_i[gidx*SW +: SW];
      wbs_cyc_o       = cyc_g & ~fire;
      wbs_stb_o       = cyc_g & stb_g & ~fire;
      wbm_dat_o       = wbs_dat_i;
      grant_o[gidx]   = 1'b1;
      wbm_ack_o[gidx] = cyc_g & wbs_ack_i & ~fire;
      wbm_err_o[gidx] = fire | (cyc_g & wbs_err_i);
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter
// Directed scenarios plus a randomized run against a behavioural model of the
// round-robin arbiter (NMASTERS=4, TIMEOUT_CYCLES=4 when WB_ARB_TIMEOUT_EN).

module tb_wb_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*AW-1:0] adr;
  logic [N*DW-1:0] mdat;
  logic [DW-1:0]   mdat_o;
  logic [N-1:0]    we;
  logic [N*SW-1:0] sel;
  logic [N-1:0]    stb;
  logic [N-1:0]    cyc;
  logic [N-1:0]    ack_o;
  logic [N-1:0]    err_o;
  logic [AW-1:0]   sadr;
  logic [DW-1:0]   sdat_o;
  logic            swe;
  logic [SW-1:0]   ssel;
  logic            sstb;
  logic            scyc;
  logic [DW-1:0]   sdat_i;
  logic            sack;
  logic            serr;
  logic [N-1:0]    grant;

  int compared   = 0;
  int mismatched = 0;

  wb_rr_arbiter #(
    .NMASTERS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbm_adr_i(adr), .wbm_dat_i(mdat), .wbm_dat_o(mdat_o),
    .wbm_we_i(we), .wbm_sel_i(sel), .wbm_stb_i(stb), .wbm_cyc_i(cyc),
    .wbm_ack_o(ack_o), .wbm_err_o(err_o),
    .wbs_adr_o(sadr), .wbs_dat_o(sdat_o), .wbs_we_o(swe), .wbs_sel_o(ssel),
    .wbs_stb_o(sstb), .wbs_cyc_o(scyc),
    .wbs_dat_i(sdat_i), .wbs_ack_i(sack), .wbs_err_i(serr),
    .grant_o(grant)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_inputs();
    adr = '0; mdat = '0; we = '0; sel = '0; stb = '0; cyc = '0;
    sdat_i = '0; sack = 1'b0; serr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc = '1; stb = '1; we = '1; sel = '1;
    adr = {4{32'h1234_5678}}; mdat = {4{32'hCAFE_F00D}};
    sdat_i = 32'hA5A5_5A5A; sack = 1'b1; serr = 1'b1;
    repeat (2) @(negedge clk);
    #3;
    compared++; if (grant !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
    compared++; if (scyc !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cyc: got %b expected 0", scyc); end
    compared++; if (sstb !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stb: got %b expected 0", sstb); end
    compared++; if (ack_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_ack: got %b expected 0000", ack_o); end
    compared++; if (err_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_err: got %b expected 0000", err_o); end
    compared++; if (sadr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_adr: got %h expected 0", sadr); end
    compared++; if (mdat_o !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rdata: got %h expected 0", mdat_o); end
    serr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    compared++; if (grant !== 4'b0000) begin mismatched++; $display("[TB] FAIL release_idle: got %b expected 0000", grant); end
    @(negedge clk);
    #3;
    compared++; if (grant !== 4'b0001) begin mismatched++; $display("[TB] FAIL release_grant: got %b expected 0001", grant); end
    compared++; if (scyc !== 1'b1) begin mismatched++; $display("[TB] FAIL release_cyc: got %b expected 1", scyc); end
    compared++; if (ack_o !== 4'b0001) begin mismatched++; $display("[TB] FAIL release_ack: got %b expected 0001", ack_o); end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_seq [5];
    logic [N-1:0] drop;
    logic [N-1:0] prev;
    int k;
    int zeros;
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    sack = 1'b1;
    drop = '0; prev = '0; k = 0; zeros = 0;
    for (int c = 0; c < 40 && k < 5; c++) begin
      @(negedge clk);
      cyc = ~drop; stb = ~drop;
      #3;
      if (grant !== 4'b0000 && prev === 4'b0000) begin
        if (k > 0) begin
          compared++; if (zeros != 1) begin mismatched++; $display("[TB] FAIL rr_gap%0d: got %0d idle cycles expected 1", k, zeros); end
        end
        compared++; if (grant !== exp_seq[k]) begin mismatched++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", k, grant, exp_seq[k]); end
        k++;
        zeros = 0;
      end
      if (grant === 4'b0000) zeros++;
      drop = ack_o;
      prev = grant;
    end
    compared++; if (k != 5) begin mismatched++; $display("[TB] FAIL rr_count: got %0d grants expected 5", k); end
    idle_inputs();
  endtask

  task automatic test_burst_hold();
    int beats;
    int early;
    int drop_c;
    int m0_c;
    do_reset();
    sack = 1'b1;
    beats = 0; early = 0; drop_c = -1; m0_c = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      cyc[1] = (beats < 4); stb[1] = (beats < 4);
      if (c >= 1) begin cyc[0] = 1'b1; stb[0] = 1'b1; end
      #3;
      if (grant[0] === 1'b1 && drop_c < 0) early = 1;
      if (ack_o[1] === 1'b1) beats++;
      if (cyc[1] == 1'b0 && drop_c < 0) drop_c = c;
      if (grant[0] === 1'b1 && m0_c < 0) m0_c = c;
    end
    compared++; if (beats != 4) begin mismatched++; $display("[TB] FAIL burst_beats: got %0d expected 4", beats); end
    compared++; if (early != 0) begin mismatched++; $display("[TB] FAIL burst_split: got %0d expected 0", early); end
    compared++; if (drop_c < 0 || m0_c != drop_c + 2) begin mismatched++; $display("[TB] FAIL burst_m0_latency: got cycle %0d expected %0d", m0_c, drop_c + 2); end
    idle_inputs();
  endtask

  task automatic test_abort_reset();
    do_reset();
    @(negedge clk);
    cyc = 4'b0100; stb = 4'b0100;
    @(negedge clk);
    #3;
    compared++; if (grant !== 4'b0100) begin mismatched++; $display("[TB] FAIL abort_pre_grant: got %b expected 0100", grant); end
    compared++; if (scyc !== 1'b1) begin mismatched++; $display("[TB] FAIL abort_pre_cyc: got %b expected 1", scyc); end
    rst_n = 1'b0;
    sack = 1'b1;
    #1;
    compared++; if (scyc !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_cyc: got %b expected 0", scyc); end
    compared++; if (sstb !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_stb: got %b expected 0", sstb); end
    compared++; if (ack_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL midreset_ack: got %b expected 0000", ack_o); end
    do_reset();
    @(negedge clk);
    cyc = 4'b0100; stb = 4'b0100;
    @(negedge clk);
    cyc = 4'b1101; stb = 4'b1101;
    @(negedge clk);
    @(negedge clk);
    cyc = 4'b1001; stb = 4'b1101; sack = 1'b1;
    #3;
    compared++; if (ack_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL abort_ack: got %b expected 0000", ack_o); end
    compared++; if (scyc !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_cyc: got %b expected 0", scyc); end
    @(negedge clk);
    sack = 1'b0;
    #3;
    compared++; if (grant !== 4'b0000) begin mismatched++; $display("[TB] FAIL abort_idle: got %b expected 0000", grant); end
    @(negedge clk);
    #3;
    compared++; if (grant !== 4'b1000) begin mismatched++; $display("[TB] FAIL abort_ptr: got %b expected 1000", grant); end
    idle_inputs();
  endtask

  task automatic test_timeout();
    logic exp_err;
    do_reset();
    @(negedge clk);
    cyc = 4'b0001; stb = 4'b0001;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      #3;
`ifdef WB_ARB_TIMEOUT_EN
      exp_err = ((c % (TO + 1)) == 0);
`else
      exp_err = 1'b0;
`endif
      compared++; if (err_o !== {3'b000, exp_err}) begin mismatched++; $display("[TB] FAIL stall_err_c%0d: got %b expected %b", c, err_o, {3'b000, exp_err}); end
      compared++; if (sstb !== ~exp_err) begin mismatched++; $display("[TB] FAIL stall_stb_c%0d: got %b expected %b", c, sstb, ~exp_err); end
      compared++; if (grant !== 4'b0001) begin mismatched++; $display("[TB] FAIL stall_grant_c%0d: got %b expected 0001", c, grant); end
    end
    idle_inputs();
  endtask

  task automatic test_err_route();
    do_reset();
    @(negedge clk);
    cyc = 4'b0100; stb = 4'b0100;
    @(negedge clk);
    cyc = 4'b1111; stb = 4'b1111; serr = 1'b1;
    #3;
    compared++; if (err_o !== 4'b0100) begin mismatched++; $display("[TB] FAIL err_route: got %b expected 0100", err_o); end
    compared++; if (ack_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL err_route_ack: got %b expected 0000", ack_o); end
    @(negedge clk);
    serr = 1'b0;
    #3;
    compared++; if (err_o !== 4'b0000) begin mismatched++; $display("[TB] FAIL err_clear: got %b expected 0000", err_o); end
    idle_inputs();
  endtask

  task automatic test_random();
    int owner;
    int ptr;
    int stall;
    logic          fire;
    logic          cg;
    logic [N-1:0]  e_grant, e_ack, e_err;
    logic          e_cyc, e_stb, e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat, e_rdat;
    logic [SW-1:0] e_sel;
    do_reset();
    owner = -1; ptr = 0; stall = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (cyc[i]) cyc[i] = ($urandom_range(0, 3) != 0);
        else        cyc[i] = ($urandom_range(0, 2) == 0);
        stb[i] = cyc[i] & ($urandom_range(0, 3) != 0);
        we[i]  = $urandom_range(0, 1);
        adr[i*AW +: AW] = $urandom;
        mdat[i*DW +: DW] = $urandom;
        sel[i*SW +: SW] = SW'($urandom);
      end
      sack = $urandom_range(0, 1);
      serr = ($urandom_range(0, 15) == 0);
      sdat_i = $urandom;
      #3;
      fire = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      fire = (owner >= 0) && (stall == TO);
`endif
      e_grant = '0; e_ack = '0; e_err = '0;
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0;
      e_adr = '0; e_dat = '0; e_rdat = '0; e_sel = '0;
      cg = 1'b0;
      if (owner >= 0) begin
        cg = cyc[owner];
        e_grant[owner] = 1'b1;
        e_cyc = cg & ~fire;
        e_stb = cg & stb[owner] & ~fire;
        e_we  = we[owner];
        e_adr = adr[owner*AW +: AW];
        e_dat = mdat[owner*DW +: DW];
        e_sel = sel[owner*SW +: SW];
        e_rdat = sdat_i;
        e_ack[owner] = cg & sack & ~fire;
        e_err[owner] = fire | (cg & serr);
      end
      compared++; if (grant !== e_grant) begin mismatched++; $display("[TB] FAIL rnd_grant c%0d: got %b expected %b", c, grant, e_grant); end
      compared++; if (scyc !== e_cyc) begin mismatched++; $display("[TB] FAIL rnd_cyc c%0d: got %b expected %b", c, scyc, e_cyc); end
      compared++; if (sstb !== e_stb) begin mismatched++; $display("[TB] FAIL rnd_stb c%0d: got %b expected %b", c, sstb, e_stb); end
      compared++; if (sadr !== e_adr) begin mismatched++; $display("[TB] FAIL rnd_adr c%0d: got %h expected %h", c, sadr, e_adr); end
      compared++; if (sdat_o !== e_dat) begin mismatched++; $display("[TB] FAIL rnd_wdat c%0d: got %h expected %h", c, sdat_o, e_dat); end
      compared++; if (swe !== e_we) begin mismatched++; $display("[TB] FAIL rnd_we c%0d: got %b expected %b", c, swe, e_we); end
      compared++; if (ssel !== e_sel) begin mismatched++; $display("[TB] FAIL rnd_sel c%0d: got %h expected %h", c, ssel, e_sel); end
      compared++; if (ack_o !== e_ack) begin mismatched++; $display("[TB] FAIL rnd_ack c%0d: got %b expected %b", c, ack_o, e_ack); end
      compared++; if (err_o !== e_err) begin mismatched++; $display("[TB] FAIL rnd_err c%0d: got %b expected %b", c, err_o, e_err); end
      compared++; if (mdat_o !== e_rdat) begin mismatched++; $display("[TB] FAIL rnd_rdat c%0d: got %h expected %h", c, mdat_o, e_rdat); end
`ifdef WB_ARB_TIMEOUT_EN
      if (owner >= 0 && e_stb && !sack && !serr) stall++;
      else stall = 0;
`endif
      if (owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (owner < 0 && cyc[(ptr + k) % N]) owner = (ptr + k) % N;
        end
      end else if (!cyc[owner]) begin
        ptr = (owner + 1) % N;
        owner = -1;
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_round_robin();
    test_burst_hold();
    test_abort_reset();
    test_timeout();
    test_err_route();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
